// File: rtl/vgm_psg_player.sv
// VGM command sequencer for a YM2149 PSG register-write port.
// Decodes AY writes, sample-paced waits and end-of-stream from a byte stream.
module vgm_psg_player #(
  parameter int CLK_PER_SAMPLE = 567,
  parameter int WR_HIGH        = 2,
  parameter int WR_LOW         = 2
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  output logic [3:0] out_reg,
  output logic [7:0] out_val,
  output logic       out_wr,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_err
);

  localparam int PW   = $clog2(CLK_PER_SAMPLE + 1);
  localparam int WMAX = (WR_HIGH > WR_LOW) ? WR_HIGH : WR_LOW;
  localparam int WW   = $clog2(WMAX + 1);

  typedef enum logic [2:0] {
    S_OP, S_A1, S_A2, S_WR_HI, S_WR_LO, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t          r_state, w_state_n;
  logic            r_is_wait, w_is_wait_n;
  logic [7:0]      r_byte1, w_byte1_n;
  logic [15:0]     r_samp, w_samp_n;
  logic [PW-1:0]   r_presc, w_presc_n;
  logic [WW-1:0]   r_wcnt, w_wcnt_n;
  logic [3:0]      r_reg, w_reg_n;
  logic [7:0]      r_val, w_val_n;
  logic            w_fetch, w_xfer;
  logic [15:0]     w_n61;

  assign w_fetch = (r_state == S_OP) || (r_state == S_A1) || (r_state == S_A2);
  assign w_xfer  = w_fetch && in_valid;
  assign w_n61   = {in_data, r_byte1};

  always_comb begin
    w_state_n   = r_state;
    w_is_wait_n = r_is_wait;
    w_byte1_n   = r_byte1;
    w_samp_n    = r_samp;
    w_presc_n   = r_presc;
    w_wcnt_n    = r_wcnt;
    w_reg_n     = r_reg;
    w_val_n     = r_val;
    case (r_state)
      S_OP: if (w_xfer) begin
        casez (in_data)
          8'hA0: begin w_is_wait_n = 1'b0; w_state_n = S_A1; end
          8'h61: begin w_is_wait_n = 1'b1; w_state_n = S_A1; end
          8'h62: begin
            w_samp_n  = 16'd735;
            w_presc_n = PW'(CLK_PER_SAMPLE - 1);
            w_state_n = S_WAIT;
          end
          8'h63: begin
            w_samp_n  = 16'd882;
            w_presc_n = PW'(CLK_PER_SAMPLE - 1);
            w_state_n = S_WAIT;
          end
          8'b0111_????: begin
            w_samp_n  = {12'd0, in_data[3:0]} + 16'd1;
            w_presc_n = PW'(CLK_PER_SAMPLE - 1);
            w_state_n = S_WAIT;
          end
          8'h66:   w_state_n = S_DONE;
          default: w_state_n = S_ERR;
        endcase
      end
      S_A1: if (w_xfer) begin
        w_byte1_n = in_data;
        w_state_n = S_A2;
      end
      S_A2: if (w_xfer) begin
        if (r_is_wait) begin
          if (w_n61 == 16'd0) begin
            w_state_n = S_OP;
          end else begin
            w_samp_n  = w_n61;
            w_presc_n = PW'(CLK_PER_SAMPLE - 1);
            w_state_n = S_WAIT;
          end
        end else if (r_byte1[7]) begin
          // address with bit7 set targets a second chip we do not drive
          w_state_n = S_OP;
        end else begin
          w_reg_n   = r_byte1[3:0];
          w_val_n   = in_data;
          w_wcnt_n  = WW'(WR_HIGH - 1);
          w_state_n = S_WR_HI;
        end
      end
      S_WR_HI: begin
        if (r_wcnt == '0) begin
          w_wcnt_n  = WW'(WR_LOW - 1);
          w_state_n = S_WR_LO;
        end else begin
          w_wcnt_n = r_wcnt - 1'b1;
        end
      end
      S_WR_LO: begin
        if (r_wcnt == '0) w_state_n = S_OP;
        else              w_wcnt_n  = r_wcnt - 1'b1;
      end
      S_WAIT: begin
        if (r_presc == '0) begin
          w_presc_n = PW'(CLK_PER_SAMPLE - 1);
          w_samp_n  = r_samp - 16'd1;
          if (r_samp == 16'd1) w_state_n = S_OP;
        end else begin
          w_presc_n = r_presc - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      r_state   <= S_OP;
      r_is_wait <= 1'b0;
      r_byte1   <= '0;
      r_samp    <= '0;
      r_presc   <= '0;
      r_wcnt    <= '0;
      r_reg     <= '0;
      r_val     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_is_wait <= w_is_wait_n;
      r_byte1   <= w_byte1_n;
      r_samp    <= w_samp_n;
      r_presc   <= w_presc_n;
      r_wcnt    <= w_wcnt_n;
      r_reg     <= w_reg_n;
      r_val     <= w_val_n;
    end
  end

  // Strobes are gated by reset so a write pulse dies as soon as reset is applied.
  assign out_ready = in_rst && w_fetch;
  assign out_wr    = in_rst && (r_state == S_WR_HI);
  assign out_busy  = in_rst && ((r_state == S_WR_HI) || (r_state == S_WR_LO) ||
                                (r_state == S_WAIT));
  assign out_done  = in_rst && (r_state == S_DONE);
  assign out_err   = in_rst && (r_state == S_ERR);
  assign out_reg   = r_reg;
  assign out_val   = r_val;

endmodule
